macplus_kbd_responder: RTL and testbench
========================================

// Module: macplus_kbd_responder
// PURPOSE
//  Mac Plus (M0110A) keyboard protocol responder. Queues 9-bit Mac key codes from the
//  HID-to-Mac key translation table and answers Mac-side commands delivered as whole bytes
//  by the shift-register link. It emits each key transition as 1-3 reply bytes, adding
//  keypad and shift prefixes. It sits between the companion key path and the VIA keyboard link.
// PARAMETERS
//  FIFO_DEPTH      8          key-event queue depth, power of two, >=2
//  TIMEOUT_CYCLES  8_000_000  Inquiry wait before null reply (250 ms at 32 MHz)
// PORTS
//  clk          in   1  system clock
//  reset_n      in   1  asynchronous active-low reset
//  key_valid    in   1  key event strobe, one cycle
//  key_code     in   9  {prefix[1:0], code[6:0]}: prefix 0 plain, 1 keypad, 3 keypad+shift
//  key_release  in   1  1 = key up, 0 = key down; qualified by key_valid
//  key_ready    out  1  queue not full
//  cmd_strobe   in   1  Mac command byte valid, one cycle
//  cmd          in   8  command byte
//  reply_strobe out  1  reply byte valid, one-cycle pulse
//  reply        out  8  reply byte, held until the next reply_strobe
//  overflow     out  1  sticky: an event was dropped; cleared by Model command or reset
// BEHAVIOUR
//  - Reset values: reply_strobe=0, reply=8'h00, overflow=0, queue and sequencer empty,
//    key_ready=1, state IDLE.
//  - Enqueue: accepted when key_valid && key_ready. code==7'h7F (unmapped) is discarded silently.
//    An event arriving when full is dropped and sets overflow. Prefix 2 is treated as prefix 0.
//  - Byte expansion, with r = key_release<<7:
//    prefix 0 -> {code|r}; prefix 1 -> {8'h79, code|r}; prefix 3 -> {8'h71|r, 8'h79, code|r}.
//    Each reply consumes one byte. Remaining bytes stay in the sequencer (max 2) for later Inquiry/Instant.
//  - Commands:
//    Inquiry 8'h10 / Instant 8'h14 reply with the next pending sequencer byte. If the sequencer
//    is empty, they pop the queue head. If there is no event, Instant replies 8'h7B; Inquiry moves to WAIT.
//    Model 8'h16 flushes the queue and sequencer, clears overflow, and replies 8'h0B.
//    Test 8'h36 replies 8'h7D. Any other command is ignored with no reply.
//  - States: IDLE, WAIT.
//    IDLE: immediate replies are registered, so reply_strobe occurs in cycle N+1 for cmd_strobe in cycle N.
//    WAIT: the timer counts from 0. An accepted key event in cycle M produces a reply in cycle M+1
//    (the event is popped directly) and returns to IDLE. At TIMEOUT_CYCLES the block replies 8'h7B and goes IDLE.
//    A new cmd_strobe in WAIT aborts the wait and is processed as if in IDLE.
//  - Simultaneous enqueue and pop: a pop and an enqueue in the same cycle are both honoured.
//    The full test uses the occupancy at the start of the cycle.
//  - reset_n assertion mid-sequence or mid-wait discards all state. No partial reply is emitted.
// CONFIGURATION
//  MACPLUS_CAPS_LATCH_EN defined:
//    - Caps lock (code 7'h73) behaves as a latching key. Each press toggles an internal latch and
//      enqueues 8'h73 (latch now set) or 8'hF3 (latch now clear).
//    - Caps release events are discarded. The latch resets to clear and is cleared by Model.
//  Undefined: caps press/release pass through like any other key.
// STRUCTURE
//  - Package macplus_kbd_pkg: command codes (CMD_INQUIRY, CMD_INSTANT, CMD_MODEL, CMD_TEST),
//    reply constants (RSP_NULL 8'h7B, RSP_ACK 8'h7D, RSP_MODEL 8'h0B, PFX_KEYPAD 8'h79,
//    PFX_SHIFT 8'h71), prefix enum, state enum.
//  - Sub-module macplus_kbd_fifo: synchronous FIFO, 10-bit entries {release, prefix, code},
//    push/pop/flush, full/empty. The top level holds the command FSM, sequencer, timer and caps latch.
// TESTING
//  1. cmd 8'h36 at cycle 10 -> reply_strobe at cycle 11, reply=8'h7D; cmd 8'h55 -> no reply.
//  2. Press {0,7'h01}, Inquiry -> 8'h01. Release, Instant -> 8'h81. Instant again -> 8'h7B.
//  3. Press {3,7'h11}, three Inquiries -> 8'h71, 8'h79, 8'h11. Release, three Inquiries -> 8'hF1, 8'h79, 8'h91.
//  4. Inquiry on an empty queue with no key -> 8'h7B exactly TIMEOUT_CYCLES later (TIMEOUT_CYCLES=100 in the bench).
//     Key at wait cycle 40 -> reply in the next cycle.
//  5. Push 9 events with FIFO_DEPTH=8 -> 9th dropped, overflow=1, key_ready=0. Drain returns the first 8 in order.
//     Model -> 8'h0B, overflow=0, then Instant -> 8'h7B.
//  6. MACPLUS_CAPS_LATCH_EN: caps press/release/press/release -> queue holds 8'h73, 8'hF3 only.
//     Without the macro -> 8'h73, 8'hF3, 8'h73, 8'hF3.

Source files
------------

// File: rtl/macplus_kbd_pkg.sv
// macplus_kbd_pkg: shared constants, enums and byte-expansion helper for the Mac Plus keyboard responder.
package macplus_kbd_pkg;
    localparam logic [7:0] CMD_INQUIRY   = 8'h10;
    localparam logic [7:0] CMD_INSTANT   = 8'h14;
    localparam logic [7:0] CMD_MODEL     = 8'h16;
    localparam logic [7:0] CMD_TEST      = 8'h36;
    localparam logic [7:0] RSP_NULL      = 8'h7B;
    localparam logic [7:0] RSP_ACK       = 8'h7D;
    localparam logic [7:0] RSP_MODEL     = 8'h0B;
    localparam logic [7:0] PFX_KEYPAD    = 8'h79;
    localparam logic [7:0] PFX_SHIFT     = 8'h71;
    localparam logic [6:0] CODE_UNMAPPED = 7'h7F;
    localparam logic [6:0] CODE_CAPS     = 7'h73;

    typedef enum logic [1:0] {
        PFX_PLAIN    = 2'd0,
        PFX_KP       = 2'd1,
        PFX_ALT      = 2'd2,
        PFX_KP_SHIFT = 2'd3
    } prefix_e;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    typedef struct packed {
        logic [1:0] n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } expand_t;

    // Reserved prefix 2 falls through to the plain one-byte form.
    function automatic expand_t expand_evt(input logic rel, input prefix_e pfx, input logic [6:0] code);
        logic [7:0] k;
        k = {rel, code};
        expand_evt = '{2'd1, k, 8'h00, 8'h00};
        if (pfx == PFX_KP)
            expand_evt = '{2'd2, PFX_KEYPAD, k, 8'h00};
        else if (pfx == PFX_KP_SHIFT)
            expand_evt = '{2'd3, PFX_SHIFT | {rel, 7'b0}, PFX_KEYPAD, k};
    endfunction
endpackage

// File: rtl/macplus_kbd_fifo.sv
// macplus_kbd_fifo: synchronous key-event FIFO with push, pop and flush; full/empty from pointer wrap bit.
module macplus_kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_q[AW-1:0]];

    always_comb begin
        wr_d = flush ? '0 : wr_q + {{AW{1'b0}}, do_push};
        rd_d = flush ? '0 : rd_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/macplus_kbd_responder.sv
// macplus_kbd_responder: M0110A keyboard responder - event queue, reply sequencer and Inquiry wait timer.
// Define MACPLUS_CAPS_LATCH_EN to make caps lock a latching key.
module macplus_kbd_responder
    import macplus_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 8_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       key_release,
    output logic       key_ready,
    input  logic       cmd_strobe,
    input  logic [7:0] cmd,
    output logic       reply_strobe,
    output logic [7:0] reply,
    output logic       overflow
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    // Registered reply adds a cycle, so fire one early to land exactly TIMEOUT_CYCLES after the command.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    seq0_q, seq0_d, seq1_q, seq1_d;
    logic [1:0]    seq_cnt_q, seq_cnt_d;
    logic [7:0]    reply_q, reply_d;
    logic          reply_strobe_q, reply_strobe_d;
    logic          overflow_q, overflow_d;
    logic          fifo_full, fifo_empty, push, pop, bypass;
    logic          evt_ok, evt_rel, is_model, want;
    logic [9:0]    fifo_dout, evt_word, src;
    expand_t       x;

    assign is_model = cmd_strobe && cmd == CMD_MODEL;

`ifdef MACPLUS_CAPS_LATCH_EN
    logic caps_q, caps_d, is_caps;
    assign is_caps = key_code[6:0] == CODE_CAPS;
    assign evt_ok  = key_valid && key_code[6:0] != CODE_UNMAPPED && !(is_caps && key_release);
    assign evt_rel = is_caps ? caps_q : key_release;
    always_comb caps_d = is_model ? 1'b0 : caps_q ^ (key_valid && is_caps && !key_release);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) caps_q <= 1'b0;
        else          caps_q <= caps_d;
    end
`else
    assign evt_ok  = key_valid && key_code[6:0] != CODE_UNMAPPED;
    assign evt_rel = key_release;
`endif

    assign evt_word = {evt_rel, key_code};
    assign src      = fifo_empty ? evt_word : fifo_dout;
    assign x        = expand_evt(src[9], prefix_e'(src[8:7]), src[6:0]);
    assign want     = cmd_strobe ? (cmd == CMD_INQUIRY || cmd == CMD_INSTANT) : state_q == ST_WAIT;

    macplus_kbd_fifo #(.DEPTH(FIFO_DEPTH), .W(10)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .flush  (is_model),
        .din    (evt_word),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d        = cmd_strobe ? ST_IDLE : state_q;
        timer_d        = timer_q;
        seq0_d         = seq0_q;
        seq1_d         = seq1_q;
        seq_cnt_d      = seq_cnt_q;
        reply_d        = reply_q;
        reply_strobe_d = 1'b0;
        overflow_d     = overflow_q;
        pop            = 1'b0;
        bypass         = 1'b0;
        if (want && seq_cnt_q != 2'd0) begin
            reply_d        = seq0_q;
            seq0_d         = seq1_q;
            seq_cnt_d      = seq_cnt_q - 2'd1;
            reply_strobe_d = 1'b1;
            state_d        = ST_IDLE;
        end else if (want && (!fifo_empty || evt_ok)) begin
            // With an empty queue the arriving event is expanded directly instead of being queued.
            reply_d        = x.b0;
            seq0_d         = x.b1;
            seq1_d         = x.b2;
            seq_cnt_d      = x.n - 2'd1;
            reply_strobe_d = 1'b1;
            pop            = !fifo_empty;
            bypass         = fifo_empty;
            state_d        = ST_IDLE;
        end else if (want && cmd_strobe) begin
            reply_d        = cmd == CMD_INSTANT ? RSP_NULL : reply_q;
            reply_strobe_d = cmd == CMD_INSTANT;
            state_d        = cmd == CMD_INSTANT ? ST_IDLE : ST_WAIT;
            timer_d        = '0;
        end else if (want) begin
            reply_d        = timer_q == T_LAST ? RSP_NULL : reply_q;
            reply_strobe_d = timer_q == T_LAST;
            state_d        = timer_q == T_LAST ? ST_IDLE : ST_WAIT;
            timer_d        = timer_q + 1'b1;
        end else if (is_model) begin
            seq_cnt_d      = 2'd0;
            reply_d        = RSP_MODEL;
            reply_strobe_d = 1'b1;
            overflow_d     = 1'b0;
        end else if (cmd_strobe && cmd == CMD_TEST) begin
            reply_d        = RSP_ACK;
            reply_strobe_d = 1'b1;
        end
        push = evt_ok && !bypass && !is_model && !fifo_full;
        if (evt_ok && !bypass && !is_model && fifo_full) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            seq0_q         <= 8'h00;
            seq1_q         <= 8'h00;
            seq_cnt_q      <= 2'd0;
            reply_q        <= 8'h00;
            reply_strobe_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            seq0_q         <= seq0_d;
            seq1_q         <= seq1_d;
            seq_cnt_q      <= seq_cnt_d;
            reply_q        <= reply_d;
            reply_strobe_q <= reply_strobe_d;
            overflow_q     <= overflow_d;
        end
    end

    assign key_ready    = !fifo_full;
    assign reply_strobe = reply_strobe_q;
    assign reply        = reply_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_macplus_kbd_responder.sv
// tb_macplus_kbd_responder: directed self-checking bench for macplus_kbd_responder (TIMEOUT_CYCLES=100).
// Caps expectations follow MACPLUS_CAPS_LATCH_EN when the bench is built with it.
module tb_macplus_kbd_responder;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [8:0] key_code = 9'h000;
    logic       key_release = 1'b0;
    logic       key_ready;
    logic       cmd_strobe = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       reply_strobe;
    logic [7:0] reply;
    logic       overflow;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] caps_exp [5];

    always #5 clk = ~clk;

    macplus_kbd_responder #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(100)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_release (key_release),
        .key_ready   (key_ready),
        .cmd_strobe  (cmd_strobe),
        .cmd         (cmd),
        .reply_strobe(reply_strobe),
        .reply       (reply),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic rel, input logic [8:0] code);
        key_valid = 1'b1;
        key_release = rel;
        key_code = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic cmd_tx(input logic [7:0] c);
        cmd = c;
        cmd_strobe = 1'b1;
        tick();
        cmd_strobe = 1'b0;
    endtask

    task automatic ask(input string tag, input logic [7:0] c, input logic [7:0] exp);
        cmd_tx(c);
        chk({tag, "_stb"}, reply_strobe, 1'b1);
        chk(tag, reply, exp);
        tick();
    endtask

    task automatic quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            seen |= reply_strobe;
        end
        chk(tag, seen, 1'b0);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        chk("rst_stb", reply_strobe, 1'b0);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_reply", reply, 8'h00);
        chk("rst_stb0", reply_strobe, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_ready", key_ready, 1'b1);
        reset_n = 1'b1;
        repeat (6) tick();

        ask("test", 8'h36, 8'h7D);
        chk("test_pulse", reply_strobe, 1'b0);
        cmd_tx(8'h55);
        chk("bad_cmd_stb", reply_strobe, 1'b0);
        chk("bad_cmd_hold", reply, 8'h7D);
        tick();

        key(1'b0, 9'h001);
        ask("press_inq", 8'h10, 8'h01);
        key(1'b1, 9'h001);
        ask("rel_inst", 8'h14, 8'h81);
        ask("inst_null", 8'h14, 8'h7B);

        key(1'b0, {2'd3, 7'h11});
        ask("kps_p0", 8'h10, 8'h71);
        ask("kps_p1", 8'h10, 8'h79);
        ask("kps_p2", 8'h10, 8'h11);
        key(1'b1, {2'd3, 7'h11});
        ask("kps_r0", 8'h10, 8'hF1);
        ask("kps_r1", 8'h10, 8'h79);
        ask("kps_r2", 8'h10, 8'h91);
        key(1'b0, {2'd1, 7'h22});
        ask("kp_p0", 8'h14, 8'h79);
        ask("kp_p1", 8'h14, 8'h22);
        key(1'b1, {2'd2, 7'h05});
        ask("pfx2_plain", 8'h14, 8'h85);
        key(1'b0, 9'h07F);
        ask("unmapped", 8'h14, 8'h7B);

        cmd_tx(8'h10);
        chk("wait_no_imm", reply_strobe, 1'b0);
        n = 0;
        while (!reply_strobe && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_lat", n, 99);
        chk("timeout_val", reply, 8'h7B);
        tick();

        cmd_tx(8'h10);
        quiet("wait40_quiet", 40);
        key(1'b0, 9'h033);
        chk("wait_key_stb", reply_strobe, 1'b1);
        chk("wait_key_val", reply, 8'h33);
        quiet("wait_done", 120);

        for (int i = 1; i <= 9; i++) begin
            key(1'b0, 9'(i));
            if (i == 8) chk("full_ready", key_ready, 1'b0);
        end
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_ready", key_ready, 1'b0);
        for (int i = 1; i <= 8; i++) ask("drain", 8'h14, 8'(i));
        chk("drain_ready", key_ready, 1'b1);
        chk("ovf_sticky", overflow, 1'b1);
        ask("drain_empty", 8'h14, 8'h7B);
        key(1'b0, 9'h044);
        ask("model", 8'h16, 8'h0B);
        chk("model_ovf", overflow, 1'b0);
        ask("model_flushed", 8'h14, 8'h7B);

        key(1'b0, {2'd3, 7'h12});
        ask("seq_pre_rst", 8'h10, 8'h71);
        do_reset();
        ask("seq_post_rst", 8'h14, 8'h7B);
        cmd_tx(8'h10);
        repeat (10) tick();
        do_reset();
        quiet("wait_rst_quiet", 150);
        cmd_tx(8'h10);
        repeat (5) tick();
        ask("wait_abort", 8'h36, 8'h7D);
        quiet("abort_quiet", 150);

`ifdef MACPLUS_CAPS_LATCH_EN
        caps_exp = '{8'h73, 8'hF3, 8'h7B, 8'h7B, 8'h7B};
`else
        caps_exp = '{8'h73, 8'hF3, 8'h73, 8'hF3, 8'h7B};
`endif
        key(1'b0, 9'h073);
        key(1'b1, 9'h073);
        key(1'b0, 9'h073);
        key(1'b1, 9'h073);
        for (int i = 0; i < 5; i++) ask("caps", 8'h14, caps_exp[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
